// File: rtl/slip_syncnt_up.sv
// Synchronous up counter with clear, parallel load, compare/auto-reload,
// sticky overflow and terminal-count output for cascading stages.
module slip_syncnt_up #(
    parameter int unsigned           WIDTH     = 9,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             CE,
    input  logic             CLL,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             CMPWR,
    input  logic [WIDTH-1:0] CMPD,
    input  logic             AUTORL,
    input  logic             OVFCLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QB,
    output logic             TC,
    output logic             MATCH,
    output logic             OVF
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;

    logic all_ones;
    logic eq;
    logic count_ok;
    logic wrap;

    assign all_ones = &q_q;
    assign eq       = (q_q == cmp_q);
    // Counting qualifies only when no clear, load or reset overrides it.
    assign count_ok = CE & CLL & ~LD & ~RESET;
    assign wrap     = count_ok & all_ones & ~(AUTORL & eq);

    always_comb begin
        q_d = q_q;
        if (RESET) begin
            q_d = RESET_VAL;
        end else if (!CLL) begin
            q_d = '0;
        end else if (LD) begin
            q_d = D;
        end else if (CE && AUTORL && eq) begin
            q_d = '0;
        end else if (CE) begin
            q_d = q_q + 1'b1;
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        if (RESET) begin
            cmp_d = RESET_VAL;
        end else if (CMPWR) begin
            cmp_d = CMPD;
        end
    end

    always_comb begin
        match_d = count_ok & eq;
        ovf_d   = ovf_q;
        if (RESET) begin
            ovf_d = 1'b0;
        end else if (wrap) begin
            ovf_d = 1'b1;
        end else if (OVFCLR) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge MasterClock) begin
        q_q     <= q_d;
        cmp_q   <= cmp_d;
        match_q <= match_d;
        ovf_q   <= ovf_d;
    end

    assign Q     = q_q;
    assign QB    = ~q_q;
    assign TC    = CE & all_ones;
    assign MATCH = match_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_slip_syncnt_up.sv
// Directed-vector bench for slip_syncnt_up: single stage plus a two-stage
// cascade, checked against hand-computed values.
module tb_slip_syncnt_up;

    localparam int unsigned WIDTH = 9;

    logic             clk;
    logic             rst, ce, cll, ld, cmpwr, autorl, ovfclr;
    logic [WIDTH-1:0] d, cmpd;
    logic [WIDTH-1:0] q, qb;
    logic             tc, match, ovf;

    // Cascade signals
    logic             c_rst, c_ld, lo_ce;
    logic [WIDTH-1:0] lo_d, hi_d;
    logic [WIDTH-1:0] lo_q, lo_qb, hi_q, hi_qb;
    logic             lo_tc, lo_match, lo_ovf, hi_tc, hi_match, hi_ovf;

    int n_cmp;
    int n_bad;

    slip_syncnt_up #(.WIDTH(WIDTH)) u_dut (
        .MasterClock(clk), .RESET(rst), .CE(ce), .CLL(cll), .LD(ld), .D(d),
        .CMPWR(cmpwr), .CMPD(cmpd), .AUTORL(autorl), .OVFCLR(ovfclr),
        .Q(q), .QB(qb), .TC(tc), .MATCH(match), .OVF(ovf)
    );

    slip_syncnt_up #(.WIDTH(WIDTH)) u_lo (
        .MasterClock(clk), .RESET(c_rst), .CE(lo_ce), .CLL(1'b1), .LD(c_ld), .D(lo_d),
        .CMPWR(1'b0), .CMPD('0), .AUTORL(1'b0), .OVFCLR(1'b0),
        .Q(lo_q), .QB(lo_qb), .TC(lo_tc), .MATCH(lo_match), .OVF(lo_ovf)
    );

    slip_syncnt_up #(.WIDTH(WIDTH)) u_hi (
        .MasterClock(clk), .RESET(c_rst), .CE(lo_tc), .CLL(1'b1), .LD(c_ld), .D(hi_d),
        .CMPWR(1'b0), .CMPD('0), .AUTORL(1'b0), .OVFCLR(1'b0),
        .Q(hi_q), .QB(hi_qb), .TC(hi_tc), .MATCH(hi_match), .OVF(hi_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] seq_q [14] = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd0, 9'd1,
                                     9'd2, 9'd3, 9'd4, 9'd5, 9'd0, 9'd1, 9'd2};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; ce = 1'b0; cll = 1'b1; ld = 1'b0; d = '0;
        cmpwr = 1'b0; cmpd = '0; autorl = 1'b0; ovfclr = 1'b0;
        c_rst = 1'b1; c_ld = 1'b0; lo_ce = 1'b0; lo_d = '0; hi_d = '0;

        // Reset state
        step(); step();
        rst = 1'b0; c_rst = 1'b0;
        step();
        chk("reset_q", q, 0);
        chk("reset_qb", qb, 9'h1FF);
        chk("reset_match", match, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_tc", tc, 0);

        // Auto-reload with CMP = 5
        cmpwr = 1'b1; cmpd = 9'd5; autorl = 1'b1;
        step();
        cmpwr = 1'b0;
        chk("cmpwr_hold_q", q, 0);
        ce = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("arl_q[%0d]", i), q, seq_q[i]);
            chk($sformatf("arl_match[%0d]", i), match, (seq_q[i] == 0) ? 1 : 0);
            chk($sformatf("arl_ovf[%0d]", i), ovf, 0);
        end

        // CE low: hold, no MATCH, no TC
        ce = 1'b0;
        step();
        chk("ce_low_hold_q", q, 2);
        chk("ce_low_match", match, 0);

        // Free-run wrap and overflow
        autorl = 1'b0; ld = 1'b1; d = 9'h1FE;
        step();
        chk("load_q", q, 9'h1FE);
        ld = 1'b0; ce = 1'b1;
        step();
        chk("wrap_q0", q, 9'h1FF);
        chk("wrap_tc", tc, 1);
        chk("wrap_ovf0", ovf, 0);
        step();
        chk("wrap_q1", q, 9'h000);
        chk("wrap_ovf1", ovf, 1);
        chk("wrap_tc_off", tc, 0);
        step();
        chk("wrap_q2", q, 9'h001);
        chk("wrap_ovf2", ovf, 1);
        ce = 1'b0; ovfclr = 1'b1;
        step();
        chk("ovfclr", ovf, 0);
        chk("ce_low_tc", tc, 0);
        ovfclr = 1'b0;

        // Overflow set beats OVFCLR
        ld = 1'b1; d = 9'h1FF;
        step();
        ld = 1'b0; ce = 1'b1; ovfclr = 1'b1;
        step();
        chk("setclr_q", q, 0);
        chk("setclr_ovf", ovf, 1);
        ce = 1'b0; ovfclr = 1'b1;
        step();
        ovfclr = 1'b0;
        chk("setclr_cleared", ovf, 0);

        // Clear beats load
        ld = 1'b1; d = 9'd3;
        step();
        ce = 1'b1; cll = 1'b0; ld = 1'b1; d = 9'h77;
        step();
        chk("clr_ld_q", q, 0);
        chk("clr_ld_match", match, 0);
        cll = 1'b1; ld = 1'b0;
        step();
        chk("after_clr_q", q, 1);

        // Load beats compare match
        ce = 1'b0; ld = 1'b1; d = 9'd5; autorl = 1'b1;
        step();
        ce = 1'b1; ld = 1'b1; d = 9'h10;
        step();
        chk("ld_vs_match_q", q, 9'h10);
        chk("ld_vs_match_match", match, 0);

        // Reset mid-count kills OVF set
        ce = 1'b0; autorl = 1'b0; ld = 1'b1; d = 9'h1FF;
        step();
        ld = 1'b0; ce = 1'b1; rst = 1'b1;
        step();
        chk("rst_mid_q", q, 0);
        chk("rst_mid_ovf", ovf, 0);
        chk("rst_mid_match", match, 0);
        rst = 1'b0; ce = 1'b0;

        // Cascade
        c_ld = 1'b1; lo_d = 9'h1FF; hi_d = 9'h000;
        step();
        c_ld = 1'b0;
        step();
        chk("chain_lo_pre", lo_q, 9'h1FF);
        chk("chain_hi_idle", hi_q, 0);
        lo_ce = 1'b1;
        step();
        lo_ce = 1'b0;
        chk("chain_lo", lo_q, 0);
        chk("chain_hi", hi_q, 1);
        step();
        chk("chain_hi_hold", hi_q, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
